// File: rtl/sipo_pack.sv
`default_nettype none
// ============================================================================
// sipo_pack : serial-in/parallel-out frame packer with flush and a
//             double-buffered valid/ready frame output.
// Optional feature macro: SIPO_PACK_ZERO_PAD_EN (zero-fill unused slots).
// Revision  : 1.0
// ============================================================================
module sipo_pack #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [DATA_W-1:0]       s_data_i,
  input  logic                    flush_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [DATA_W*DEPTH-1:0] m_data_o,
  output logic [CNT_W-1:0]        m_count_o,
  output logic                    m_partial_o,
  output logic [CNT_W-1:0]        fill_o
);

`ifdef SIPO_PACK_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] asm_q, asm_d, asm_merged;
  logic [CNT_W-1:0]             fill_q, fill_d, fill_inc, wr_idx;
  logic                         pend_q, pend_d;
  logic                         m_valid_q, m_valid_d;
  logic [DATA_W*DEPTH-1:0]      m_data_q, m_data_d;
  logic [CNT_W-1:0]             m_count_q, m_count_d;
  logic                         m_partial_q, m_partial_d;
  logic                         accept, out_free, close;

  assign s_ready_o = !pend_q;
  assign accept    = s_valid_i && !pend_q;
  assign out_free  = !m_valid_q || m_ready_i;
  assign fill_inc  = fill_q + CNT_W'(accept);
  assign close     = !pend_q && ((accept && (fill_inc == C_DEPTH)) ||
                                 (flush_i && (fill_inc != '0)));

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign wr_idx = C_DEPTH - CNT_W'(1) - fill_q;
    end else begin : g_lsb_first
      assign wr_idx = fill_q;
    end
  endgenerate

  // Frame contents including the word accepted this cycle, so a closing
  // accept can go straight to the output register.
  always_comb begin
    asm_merged = asm_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (accept && (wr_idx == CNT_W'(i))) begin
        asm_merged[i] = s_data_i;
      end
    end
  end

  always_comb begin
    asm_d       = asm_merged;
    fill_d      = fill_inc;
    pend_d      = pend_q;
    m_valid_d   = m_valid_q && !m_ready_i;
    m_data_d    = m_data_q;
    m_count_d   = m_count_q;
    m_partial_d = m_partial_q;
    if (pend_q) begin
      if (out_free) begin
        m_valid_d   = 1'b1;
        m_data_d    = asm_q;
        m_count_d   = fill_q;
        m_partial_d = (fill_q != C_DEPTH);
        pend_d      = 1'b0;
        fill_d      = '0;
        if (ZERO_PAD) asm_d = '0;
      end
    end else if (close) begin
      if (out_free) begin
        m_valid_d   = 1'b1;
        m_data_d    = asm_merged;
        m_count_d   = fill_inc;
        m_partial_d = (fill_inc != C_DEPTH);
        fill_d      = '0;
        if (ZERO_PAD) asm_d = '0;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      asm_q       <= '0;
      fill_q      <= '0;
      pend_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_count_q   <= '0;
      m_partial_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      fill_q      <= fill_d;
      pend_q      <= pend_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_count_q   <= m_count_d;
      m_partial_q <= m_partial_d;
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign m_count_o   = m_count_q;
  assign m_partial_o = m_partial_q;
  assign fill_o      = fill_q;

endmodule
`default_nettype wire
